// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the divider issue controller.
// Op encoding: bit0 selects signed division, bit1 selects the remainder.
package div_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESULT,
    DRAIN
  } state_div_issue_t;

  localparam int OP_SIGNED_BIT    = 0;
  localparam int OP_REM_BIT       = 1;
  localparam int DIV_WATCHDOG_MAX = 255;

endpackage

// File: rtl/div_issue_ctrl_special_case.sv
// Combinational detector for ops that never reach the divider:
// zero denominator and the signed most-negative / -1 overflow.
module div_special_case
  import div_issue_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  is_signed,
  input  logic                  want_rem,
  input  logic [DATA_WIDTH-1:0] num,
  input  logic [DATA_WIDTH-1:0] denom,
  output logic                  bypass,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] MINUS_ONE = '1;

  logic signed [DATA_WIDTH-1:0] num_s;
  logic signed [DATA_WIDTH-1:0] denom_s;
  logic                         denom_zero;
  logic                         overflow;

  assign num_s   = num;
  assign denom_s = denom;

  always_comb begin
    denom_zero = (denom == '0);
    overflow   = is_signed && (num_s == MOST_NEG) && (denom_s == MINUS_ONE);
    bypass     = denom_zero || overflow;
    result     = '0;
    if (denom_zero) begin
      result = want_rem ? num : '1;
    end else if (overflow) begin
      result = want_rem ? '0 : num;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue controller in front of the iterative divider: accepts one op, resolves
// trivial cases locally, sequences the divider handshake and returns the result.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_num,
  input  logic [DATA_WIDTH-1:0] in_denom,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic                  in_flush,
  output logic                  out_div_enable,
  output logic                  out_div_unsgn_or_sgn,
  output logic [DATA_WIDTH-1:0] out_div_num,
  output logic [DATA_WIDTH-1:0] out_div_denom,
  input  logic [DATA_WIDTH-1:0] in_div_quot,
  input  logic [DATA_WIDTH-1:0] in_div_rem,
  input  logic                  in_div_can_accept_cmd,
  input  logic                  in_div_data_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  typedef struct packed {
    logic                  is_signed;
    logic                  want_rem;
    logic [DATA_WIDTH-1:0] num;
    logic [DATA_WIDTH-1:0] denom;
    logic [TAG_WIDTH-1:0]  tag;
  } div_op_t;

  state_div_issue_t      state_q;
  state_div_issue_t      state_next;
  div_op_t               op_q;
  logic                  can_prev_q;
  logic [7:0]            wd_q;
  logic                  err_timeout;

  logic                  accept;
  logic                  can_rise;
  logic                  wd_active;
  logic                  wd_expired;
  logic                  wd_abort;
  logic                  bypass;
  logic [DATA_WIDTH-1:0] bypass_result;
  logic [DATA_WIDTH-1:0] div_result;
  logic                  unused_monitor;

  div_special_case #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_special (
    .is_signed(op_q.is_signed),
    .want_rem (op_q.want_rem),
    .num      (op_q.num),
    .denom    (op_q.denom),
    .bypass   (bypass),
    .result   (bypass_result)
  );

  assign accept     = in_valid && in_ready && !in_flush;
  // data_ready may still be high from the previous op, so completion is taken
  // only from the rising edge of can_accept_cmd.
  assign can_rise   = in_div_can_accept_cmd && !can_prev_q;
  assign wd_active  = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE) || (state_q == DRAIN);
  assign wd_expired = wd_active && (wd_q == 8'(DIV_WATCHDOG_MAX));
  assign div_result = op_q.want_rem ? in_div_rem : in_div_quot;

  assign out_div_unsgn_or_sgn = op_q.is_signed;
  assign out_div_num          = op_q.num;
  assign out_div_denom        = op_q.denom;

  assign unused_monitor = in_div_data_ready ^ err_timeout;

  always_comb begin
    state_next = state_q;
    wd_abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_next = ISSUE;
      end
      ISSUE: begin
        if (in_flush)                   state_next = IDLE;
        else if (bypass)                state_next = RESULT;
        else if (in_div_can_accept_cmd) state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (in_flush)                    state_next = DRAIN;
        else if (!in_div_can_accept_cmd) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A flush coinciding with completion has nothing left to drain.
        if (in_flush && can_rise) state_next = IDLE;
        else if (in_flush)        state_next = DRAIN;
        else if (can_rise)        state_next = RESULT;
      end
      RESULT: begin
        if (in_flush || out_ready) state_next = IDLE;
      end
      DRAIN: begin
        if (can_rise) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (wd_expired && (state_next == WAIT_BUSY || state_next == WAIT_DONE ||
                       state_next == DRAIN)) begin
      state_next = IDLE;
      wd_abort   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      op_q           <= '0;
      can_prev_q     <= 1'b0;
      wd_q           <= '0;
      err_timeout    <= 1'b0;
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      out_div_enable <= 1'b0;
      out_data       <= '0;
      out_tag        <= '0;
    end else begin
      state_q        <= state_next;
      can_prev_q     <= in_div_can_accept_cmd;
      in_ready       <= (state_next == IDLE);
      out_valid      <= (state_next == RESULT);
      out_div_enable <= (state_q == ISSUE) && (state_next == WAIT_BUSY);
      wd_q           <= wd_active ? wd_q + 8'd1 : 8'd0;
      if (wd_abort) begin
        err_timeout <= 1'b1;
      end
      if (accept) begin
        op_q.is_signed <= in_op[OP_SIGNED_BIT];
        op_q.want_rem  <= in_op[OP_REM_BIT];
        op_q.num       <= in_num;
        op_q.denom     <= in_denom;
        op_q.tag       <= in_tag;
      end
      // Result and tag are loaded once on entry and then held through backpressure.
      if ((state_q != RESULT) && (state_next == RESULT)) begin
        out_data <= (state_q == ISSUE) ? bypass_result : div_result;
        out_tag  <= op_q.tag;
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a behavioural divider and result model.
`timescale 1ns/1ps
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  localparam int DW = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = '0;
  logic [DW-1:0] in_num = '0;
  logic [DW-1:0] in_denom = '0;
  logic [TW-1:0] in_tag = '0;
  logic          in_flush = 1'b0;
  logic          out_div_enable;
  logic          out_div_unsgn_or_sgn;
  logic [DW-1:0] out_div_num;
  logic [DW-1:0] out_div_denom;
  logic [DW-1:0] div_quot;
  logic [DW-1:0] div_rem;
  logic          div_can;
  logic          div_dr;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  div_issue_ctrl #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_num(in_num), .in_denom(in_denom), .in_tag(in_tag), .in_flush(in_flush),
    .out_div_enable(out_div_enable), .out_div_unsgn_or_sgn(out_div_unsgn_or_sgn),
    .out_div_num(out_div_num), .out_div_denom(out_div_denom),
    .in_div_quot(div_quot), .in_div_rem(div_rem),
    .in_div_can_accept_cmd(div_can), .in_div_data_ready(div_dr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  // Architectural result: RISC-V style division computed in 64-bit arithmetic.
  function automatic logic [DW-1:0] ref_result(input logic [1:0] op, input logic [DW-1:0] n,
                                               input logic [DW-1:0] d);
    longint sn, sd, q, r;
    if (op[0]) begin
      sn = longint'($signed(n));
      sd = longint'($signed(d));
    end else begin
      sn = longint'({32'd0, n});
      sd = longint'({32'd0, d});
    end
    if (sd == 0) begin
      q = -1;
      r = sn;
    end else begin
      q = sn / sd;
      r = sn % sd;
    end
    return op[1] ? DW'(r) : DW'(q);
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [DW-1:0] n,
                                    input logic [DW-1:0] d);
    return (d == 0) || (op[0] && n == 32'h8000_0000 && d == 32'hFFFF_FFFF);
  endfunction

  // Divider model: busy for div_lat cycles after a start, garbage outputs while busy.
  int div_lat = 3;
  bit div_hang = 1'b0;
  int div_cnt;
  logic [DW-1:0] pend_q, pend_r;
  int en_total = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_can  <= 1'b1;
      div_dr   <= 1'b0;
      div_quot <= '0;
      div_rem  <= '0;
      div_cnt  <= 0;
    end else if (div_can) begin
      if (out_div_enable) begin
        div_can  <= 1'b0;
        div_dr   <= 1'b0;
        div_cnt  <= div_lat;
        pend_q   <= ref_result({1'b0, out_div_unsgn_or_sgn}, out_div_num, out_div_denom);
        pend_r   <= ref_result({1'b1, out_div_unsgn_or_sgn}, out_div_num, out_div_denom);
        div_quot <= DW'($urandom);
        div_rem  <= DW'($urandom);
      end
    end else if (!div_hang) begin
      if (div_cnt <= 1) begin
        div_can  <= 1'b1;
        div_dr   <= 1'b1;
        div_quot <= pend_q;
        div_rem  <= pend_r;
      end else begin
        div_cnt <= div_cnt - 1;
      end
    end
  end

  always @(negedge clk) if (out_div_enable) en_total++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one op from a negedge; returns result, latency from accept and enable count.
  task automatic run_op(input logic [1:0] op, input logic [DW-1:0] n, input logic [DW-1:0] d,
                        input logic [TW-1:0] t, input int hold,
                        output logic [DW-1:0] data, output logic [TW-1:0] tg,
                        output int lat, output int ens, output int stable, output bit got);
    int en0;
    int w;
    got = 1'b0; lat = 0; stable = 0; data = '0; tg = '0; w = 0;
    while (!in_ready && w < 400) begin @(negedge clk); w++; end
    en0 = en_total;
    in_valid = 1'b1; in_op = op; in_num = n; in_denom = d; in_tag = t;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 400) begin @(negedge clk); lat++; end
    if (out_valid) begin
      got = 1'b1;
      data = out_data;
      tg = out_tag;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (out_valid && out_data == data && out_tag == tg && !in_ready) stable++;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    ens = en_total - en0;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [DW-1:0] n, input logic [DW-1:0] d);
    int w;
    w = 0;
    while (!in_ready && w < 400) begin @(negedge clk); w++; end
    in_valid = 1'b1; in_op = op; in_num = n; in_denom = d; in_tag = 4'h6;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] num;
    logic [DW-1:0] denom;
    logic [TW-1:0] tag;
    logic [DW-1:0] exp;
    bit            special;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1ms;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [DW-1:0] data, n, d;
    logic [TW-1:0] tg;
    logic [1:0] op;
    int lat, ens, stable, w, en0;
    bit got, seen_valid, spec;

    vecs[0]  = '{2'b00, 32'd100,        32'd7,          4'h1, 32'h0000_000E, 1'b0};
    vecs[1]  = '{2'b11, 32'hFFFF_FF9C,  32'd7,          4'h2, 32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{2'b01, 32'hFFFF_FF9C,  32'd7,          4'h3, 32'hFFFF_FFF2, 1'b0};
    vecs[3]  = '{2'b00, 32'd5,          32'd0,          4'h4, 32'hFFFF_FFFF, 1'b1};
    vecs[4]  = '{2'b10, 32'd5,          32'd0,          4'h5, 32'h0000_0005, 1'b1};
    vecs[5]  = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  4'h6, 32'h8000_0000, 1'b1};
    vecs[6]  = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  4'h7, 32'h0000_0000, 1'b1};
    vecs[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  4'h8, 32'h0000_0000, 1'b0};
    vecs[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  4'h9, 32'h8000_0000, 1'b0};
    vecs[9]  = '{2'b01, 32'd7,          32'd0,          4'hA, 32'hFFFF_FFFF, 1'b1};
    vecs[10] = '{2'b11, 32'hFFFF_FFF9,  32'd0,          4'hB, 32'hFFFF_FFF9, 1'b1};
    vecs[11] = '{2'b00, 32'd9,          32'd3,          4'hC, 32'h0000_0003, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ctrl", {in_ready, out_valid, out_div_enable, out_div_unsgn_or_sgn}, 4'b1000);
    check("rst_data", {out_data, out_div_num}, 64'd0);
    check("rst_tag_denom", {out_tag, out_div_denom}, 64'd0);
    check("rst_timeout", dut.err_timeout, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    div_lat = 3;
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].num, vecs[i].denom, vecs[i].tag, 0, data, tg, lat, ens, stable, got);
      check($sformatf("vec%0d_valid", i), got, 1'b1);
      check($sformatf("vec%0d_data", i), data, vecs[i].exp);
      check($sformatf("vec%0d_tag", i), tg, vecs[i].tag);
      check($sformatf("vec%0d_enables", i), ens, vecs[i].special ? 0 : 1);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].special ? 2 : div_lat + 4);
      check($sformatf("vec%0d_post", i), {out_valid, in_ready}, 2'b01);
    end

    // Flush together with in_valid in IDLE rejects the op
    en0 = en_total;
    in_valid = 1'b1; in_flush = 1'b1; in_op = 2'b00; in_num = 32'd50; in_denom = 32'd5;
    @(negedge clk);
    in_valid = 1'b0; in_flush = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_flush_reject", {in_ready, out_valid, dut.state_q == IDLE}, 3'b101);
    check("idle_flush_no_enable", en_total - en0, 0);

    // Flush and out_ready together in RESULT: flush wins, output drops
    start_op(2'b00, 32'd5, 32'd0);
    w = 0;
    while (!out_valid && w < 20) begin @(negedge clk); w++; end
    check("result_flush_reached", out_valid, 1'b1);
    in_flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_flush = 1'b0; out_ready = 1'b0;
    check("result_flush_drop", {out_valid, in_ready}, 2'b01);

    // Flush 3 cycles into WAIT_DONE: drain the divider, then accept a new op
    div_lat = 10;
    start_op(2'b00, 32'd100, 32'd7);
    w = 0;
    while (dut.state_q != WAIT_DONE && w < 50) begin @(negedge clk); w++; end
    check("flush_reach_wait_done", dut.state_q == WAIT_DONE, 1'b1);
    repeat (3) @(negedge clk);
    in_flush = 1'b1;
    @(negedge clk);
    in_flush = 1'b0;
    check("drain_ready_low", {in_ready, div_can}, 2'b00);
    seen_valid = 1'b0; w = 0;
    while (!in_ready && w < 50) begin
      if (out_valid) seen_valid = 1'b1;
      @(negedge clk); w++;
    end
    check("drain_no_valid", seen_valid | out_valid, 1'b0);
    check("drain_ready_after_div", {in_ready, div_can}, 2'b11);
    check("drain_waited", w >= 2, 1'b1);
    div_lat = 3;
    run_op(2'b00, 32'd9, 32'd3, 4'hD, 0, data, tg, lat, ens, stable, got);
    check("after_drain_data", data, 32'd3);
    check("after_drain_tag", tg, 4'hD);

    // Backpressure: result held for 10 cycles
    run_op(2'b01, 32'hFFFF_FF9C, 32'd7, 4'hE, 10, data, tg, lat, ens, stable, got);
    check("hold_data", data, 32'hFFFF_FFF2);
    check("hold_stable_cycles", stable, 10);
    check("hold_post", {out_valid, in_ready}, 2'b01);

    // Randomized ops against the reference model
    for (int k = 0; k < 150; k++) begin
      op = 2'($urandom);
      case ($urandom_range(0, 9))
        0: begin n = $urandom; d = '0; end
        1: begin n = 32'h8000_0000; d = 32'hFFFF_FFFF; end
        2: begin n = $urandom_range(0, 999); d = $urandom_range(1, 20); end
        3: begin n = $urandom; d = 32'd1; end
        default: begin n = $urandom; d = $urandom; end
      endcase
      spec = is_special(op, n, d);
      div_lat = $urandom_range(1, 8);
      run_op(op, n, d, 4'($urandom), $urandom_range(0, 3), data, tg, lat, ens, stable, got);
      check($sformatf("rnd%0d_data op=%0d n=%0h d=%0h", k, op, n, d), data, ref_result(op, n, d));
      check($sformatf("rnd%0d_enables", k), ens, spec ? 0 : 1);
      check($sformatf("rnd%0d_latency", k), lat, spec ? 2 : div_lat + 4);
    end

    // Reset asserted mid-WAIT_DONE
    div_lat = 10;
    start_op(2'b01, 32'hFFFF_FF9C, 32'd7);
    w = 0;
    while (dut.state_q != WAIT_DONE && w < 50) begin @(negedge clk); w++; end
    check("rst_mid_reach", dut.state_q == WAIT_DONE, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {in_ready, out_valid, out_div_enable, out_div_unsgn_or_sgn}, 4'b1000);
    check("rst_mid_data", {out_data, out_div_num}, 64'd0);
    check("rst_mid_tag_denom", {out_tag, out_div_denom}, 64'd0);
    check("rst_mid_state", dut.state_q == IDLE, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Watchdog: divider never completes
    div_hang = 1'b1;
    start_op(2'b00, 32'd100, 32'd7);
    seen_valid = 1'b0; w = 0;
    while (!in_ready && w < 400) begin
      if (out_valid) seen_valid = 1'b1;
      @(negedge clk); w++;
    end
    check("wd_return_idle", in_ready, 1'b1);
    check("wd_no_valid", seen_valid, 1'b0);
    check("wd_window", (w >= 250) && (w <= 270), 1'b1);
    repeat (5) @(negedge clk);
    check("wd_flag_sticky", dut.err_timeout, 1'b1);
    rst_n = 1'b0;
    div_hang = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("wd_flag_cleared", dut.err_timeout, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
